// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the uart transmitter
// State encoding, parity codes and a constant-foldable clog2.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock fifo with extra-msb pointers
// Head word is presented combinationally on rdata while not empty.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    read,
  output logic [WIDTH-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_write;
  logic             do_read;

  assign do_write = write && !full;
  assign do_read  = read && !empty;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_write) wptr <= wptr + (AW+1)'(1);
      if (do_read)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered serial transmitter, start/data/parity/stop framing
// txd is registered from the current state, so the line lags the fsm by one clock.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DIVISOR    = 434,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_BITS-1:0]         data,
  input  logic                         wr,
  output logic                         full,
  output logic                         empty,
  output logic [clog2(FIFO_DEPTH):0]   count,
  output logic                         overrun,
  output logic                         busy,
  output logic                         txd
);

  localparam int BW = clog2(DIVISOR);
  localparam int CW = clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIVISOR - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] head;
  logic                 par_bit;
  logic [BW-1:0]        baud;
  logic [CW-1:0]        bit_cnt;
  logic                 pop;
  logic                 baud_wrap;

  assign pop       = (state == IDLE) && !empty;
  assign baud_wrap = (baud == BAUD_LAST);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .write (wr),
    .wdata (data),
    .read  (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset)          overrun <= 1'b0;
    else if (wr && full) overrun <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      par_bit <= 1'b0;
      baud    <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      txd     <= 1'b1;
    end else begin
      case (state)
        START:   txd <= 1'b0;
        DATA:    txd <= shift[0];
        PAR:     txd <= par_bit;
        default: txd <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            shift   <= head;
            par_bit <= (PARITY == PAR_ODD) ? ~^head : ^head;
            baud    <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud    <= '0;
            bit_cnt <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud  <= '0;
            shift <= shift >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != PAR_NONE) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        PAR: begin
          if (baud_wrap) begin
            baud    <= '0;
            bit_cnt <= '0;
            state   <= STOP;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          // bit_cnt counts whole stop bits here
          if (baud_wrap) begin
            baud <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
// Instance a: 8N1 depth 4; b: even parity 2 stop; c: odd parity 2 stop.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_a, rst_bc;
  logic [7:0] data_a, data_bc;
  logic       wr_a, wr_bc;
  logic       full_a, empty_a, ovr_a, busy_a, txd_a;
  logic       full_b, empty_b, ovr_b, busy_b, txd_b;
  logic       full_c, empty_c, ovr_c, busy_c, txd_c;
  logic [2:0] count_a, count_b, count_c;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  uart_tx_fifo #(.DIVISOR(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .reset(rst_a), .data(data_a), .wr(wr_a), .full(full_a), .empty(empty_a),
    .count(count_a), .overrun(ovr_a), .busy(busy_a), .txd(txd_a));

  uart_tx_fifo #(.DIVISOR(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .reset(rst_bc), .data(data_bc), .wr(wr_bc), .full(full_b), .empty(empty_b),
    .count(count_b), .overrun(ovr_b), .busy(busy_b), .txd(txd_b));

  uart_tx_fifo #(.DIVISOR(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_c (
    .clk(clk), .reset(rst_bc), .data(data_bc), .wr(wr_bc), .full(full_c), .empty(empty_c),
    .count(count_c), .overrun(ovr_c), .busy(busy_c), .txd(txd_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic logic txd_of(input int k);
    case (k)
      0:       return txd_a;
      1:       return txd_b;
      default: return txd_c;
    endcase
  endfunction

  function automatic int par_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
  endfunction

  function automatic int stops_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic pop_exp(input int k, output logic [7:0] d, output bit ok);
    ok = 1'b1;
    d  = '0;
    case (k)
      0:       if (q0.size() > 0) d = q0.pop_front(); else ok = 1'b0;
      1:       if (q1.size() > 0) d = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) d = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  task automatic write_a(input logic [7:0] d, input bit accept);
    data_a = d;
    wr_a   = 1'b1;
    if (accept) q0.push_back(d);
    @(negedge clk);
    wr_a = 1'b0;
  endtask

  // Waits for a start bit, samples each bit mid-way (DIVISOR=4) and checks against the scoreboard.
  task automatic rx_frame(input int k, input int gap_exp);
    int         guard;
    logic [7:0] got;
    logic [7:0] want;
    bit         ok;
    guard = 0;
    while (txd_of(k) !== 1'b0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      check("rx_timeout", 32'd0, 32'd1);
      return;
    end
    if (gap_exp >= 0) check("idle_gap", guard, gap_exp);
    repeat (2) @(negedge clk);
    check("start_bit", {31'd0, txd_of(k)}, 32'd0);
    got = '0;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      got[i] = txd_of(k);
    end
    pop_exp(k, want, ok);
    check("sb_nonempty", {31'd0, ok}, 32'd1);
    check("rx_data", got, want);
    if (par_of(k) != 0) begin
      repeat (4) @(negedge clk);
      check("parity_bit", {31'd0, txd_of(k)}, {31'd0, (par_of(k) == 1) ? ~^want : ^want});
    end
    for (int s = 0; s < stops_of(k); s++) begin
      repeat (4) @(negedge clk);
      check("stop_bit", {31'd0, txd_of(k)}, 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    rst_a = 1'b1; rst_bc = 1'b1;
    wr_a = 1'b0; wr_bc = 1'b0;
    data_a = '0; data_bc = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_bc = 1'b0;

    check("rst_txd", {31'd0, txd_a}, 32'd1);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_empty", {31'd0, empty_a}, 32'd1);
    check("rst_full", {31'd0, full_a}, 32'd0);
    check("rst_count", {29'd0, count_a}, 32'd0);
    check("rst_ovr", {31'd0, ovr_a}, 32'd0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || busy_a !== 1'b0 || empty_a !== 1'b1) bad++;
    end
    check("idle_100", bad, 32'd0);

    // single 8N1 frame: latency, busy length, bit pattern
    fork
      begin
        int lat;
        write_a(8'hA5, 1'b1);
        check("cnt_after_wr", {29'd0, count_a}, 32'd1);
        check("txd_at_wr", {31'd0, txd_a}, 32'd1);
        lat = 0;
        while (txd_a !== 1'b0 && lat < 20) begin
          @(negedge clk);
          lat++;
        end
        check("tx_latency", lat, 32'd2);
      end
      begin
        int bcnt;
        bcnt = 0;
        repeat (60) begin
          @(negedge clk);
          if (busy_a === 1'b1) bcnt++;
        end
        check("busy_len_8n1", bcnt, 32'd40);
      end
      rx_frame(0, -1);
    join
    repeat (10) @(negedge clk);

    // six back-to-back writes into depth 4 while the first frame starts
    fork
      begin
        write_a(8'h11, 1'b1);
        write_a(8'h22, 1'b1);
        write_a(8'h33, 1'b1);
        write_a(8'h44, 1'b1);
        write_a(8'h55, 1'b1);
        write_a(8'h66, 1'b0);
        check("ovf_full", {31'd0, full_a}, 32'd1);
        check("ovf_count", {29'd0, count_a}, 32'd4);
        check("ovf_overrun", {31'd0, ovr_a}, 32'd1);
      end
      begin
        rx_frame(0, -1);
        for (int i = 0; i < 4; i++) rx_frame(0, 3);
      end
    join
    repeat (5) @(negedge clk);
    check("drained_empty", {31'd0, empty_a}, 32'd1);
    check("drained_busy", {31'd0, busy_a}, 32'd0);
    check("sb_left_a", q0.size(), 32'd0);

    // write while full and the fsm is popping
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("ovr_cleared", {31'd0, ovr_a}, 32'd0);
    fork
      begin
        int guard;
        for (int i = 0; i < 5; i++) write_a(8'h81 + 8'(i), 1'b1);
        check("fill_full", {31'd0, full_a}, 32'd1);
        check("fill_no_ovr", {31'd0, ovr_a}, 32'd0);
        guard = 0;
        while (busy_a !== 1'b0 && guard < 200) begin
          @(negedge clk);
          guard++;
        end
        check("idle_reached", {31'd0, guard < 200}, 32'd1);
        check("full_at_pop", {31'd0, full_a}, 32'd1);
        write_a(8'hEE, 1'b0);
        check("drop_ovr", {31'd0, ovr_a}, 32'd1);
        check("drop_count", {29'd0, count_a}, 32'd3);
      end
      begin
        rx_frame(0, -1);
        for (int i = 0; i < 4; i++) rx_frame(0, 3);
      end
    join
    repeat (5) @(negedge clk);
    check("sb_left_full", q0.size(), 32'd0);

    // reset halfway through data bits with three words queued
    for (int i = 0; i < 4; i++) write_a(8'h90 + 8'(i), 1'b0);
    repeat (18) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy_a}, 32'd1);
    check("pre_rst_count", {29'd0, count_a}, 32'd3);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("midrst_txd", {31'd0, txd_a}, 32'd1);
    check("midrst_count", {29'd0, count_a}, 32'd0);
    check("midrst_busy", {31'd0, busy_a}, 32'd0);
    check("midrst_empty", {31'd0, empty_a}, 32'd1);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    check("no_frame_after_rst", bad, 32'd0);

    // parity instances: 0x07 has odd weight
    fork
      begin
        data_bc = 8'h07;
        wr_bc   = 1'b1;
        q1.push_back(8'h07);
        q2.push_back(8'h07);
        @(negedge clk);
        wr_bc = 1'b0;
      end
      begin
        int nb, nc;
        nb = 0;
        nc = 0;
        repeat (70) begin
          @(negedge clk);
          if (busy_b === 1'b1) nb++;
          if (busy_c === 1'b1) nc++;
        end
        check("busy_len_even", nb, 32'd48);
        check("busy_len_odd", nc, 32'd48);
      end
      rx_frame(1, -1);
      rx_frame(2, -1);
    join
    check("b_empty", {31'd0, empty_b}, 32'd1);
    check("c_empty", {31'd0, empty_c}, 32'd1);
    check("bc_flags", {26'd0, full_b, full_c, ovr_b, ovr_c, count_b[0] | count_b[1] | count_b[2],
                       count_c[0] | count_c[1] | count_c[2]}, 32'd0);
    check("sb_left_bc", q1.size() + q2.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised serial transmitter with a built-in transmit FIFO. It replaces the fixed 8N1 TX path that drives the board TXD pin in System.
- Host logic pushes words into the FIFO. An FSM serialises them onto TXD as start, data (LSB first), optional parity and 1 or 2 stop bits.
- Each bit lasts DIVISOR clocks, set at elaboration.

Parameters:
- DIVISOR, 434, clocks per serial bit (>=2); 434 gives 115200 baud at 50 MHz.
- DATA_BITS, 8, data bits per frame (5..9).
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- FIFO_DEPTH, 16, FIFO entries; must be a power of two, >=2.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- DATA  in  DATA_BITS  word to enqueue.
- WR  in  1  enqueue strobe, sampled on the rising edge of CLK.
- FULL  out  1  FIFO holds FIFO_DEPTH words.
- EMPTY  out  1  FIFO holds 0 words.
- COUNT  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- OVERRUN  out  1  sticky; set when WR is asserted while FULL.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- TXD  out  1  serial line; idle level is 1.

Behaviour:
- One clock, CLK. RESET is synchronous and active-high. All state updates on the rising edge of CLK.
- Reset values: TXD=1, BUSY=0, EMPTY=1, FULL=0, COUNT=0, OVERRUN=0, FSM in IDLE, bit and baud counters 0.
- Reset mid-frame aborts the frame. TXD returns to 1 at that edge and FIFO contents are discarded.
- Write:
  - WR && !FULL stores DATA at the tail; COUNT increments at that edge.
  - WR && FULL drops the word, leaves COUNT unchanged and sets OVERRUN.
  - OVERRUN clears only on RESET.
- Pop occurs only in IDLE with !EMPTY. It happens at the same edge as any write.
- Simultaneous write and pop with 0 < COUNT < FIFO_DEPTH: COUNT unchanged.
- Write into an empty FIFO: no pop in that cycle. The word becomes visible next cycle.
- FSM states and transitions:
  - IDLE: TXD=1. If !EMPTY, pop the head into the shift register, compute parity, go to START.
  - START: TXD=0 for DIVISOR clocks, then go to DATA.
  - DATA: TXD = shift[0]; shift right every DIVISOR clocks.
    - After DATA_BITS bits, go to PAR if PARITY != 0, else go to STOP.
  - PAR: TXD = parity bit for DIVISOR clocks.
    - Even: XOR of the data bits.
    - Odd: inverted XOR of the data bits.
  - STOP: TXD=1 for STOP_BITS*DIVISOR clocks, then go to IDLE.
- Baud counter: counts 0..DIVISOR-1 and wraps at the bit boundary.
- Bit counter: width clog2(DATA_BITS+1); cleared on entry to each state.
- Latency: a write accepted at edge N into an empty FIFO with the FSM idle gives pop at edge N+1 and TXD falling at edge N+2.
- Frame length: F = DIVISOR*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) clocks.
- Back-to-back frames: exactly 1 IDLE clock (TXD=1) between the last stop clock and the next start bit.
- BUSY is high from the edge entering START until the edge entering IDLE.
- DATA may change freely while the FSM is busy; the word is captured at pop.

Decomposition:
- Package uart_pkg holds:
  - state enum: IDLE, START, DATA, PAR, STOP;
  - parity codes: PAR_NONE, PAR_ODD, PAR_EVEN;
  - a clog2 function.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH).
  - Ports: write, read, full, empty, count.
  - Pointers are clog2(DEPTH)+1 bits; full/empty decided by the MSB compare.
- The TX FSM and counters stay in uart_tx_fifo.

Test Plan:
- Reset, then idle for 100 clocks -> TXD=1, BUSY=0, EMPTY=1 throughout.
- DIVISOR=4, 8N1, write 0xA5 once -> TXD falls 2 clocks after the write. Sampling mid-bit gives 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). BUSY high for 40 clocks.
- DIVISOR=4, PARITY=2, STOP_BITS=2, write 0x07 -> parity bit 1, two stop bits, frame 48 clocks. With PARITY=1 the parity bit is 0.
- FIFO_DEPTH=4: write 6 words in consecutive clocks while the FSM starts the first frame.
  - First word is popped, so 4 are stored, FULL=1, OVERRUN=1 and the sixth word is dropped.
  - The 5 accepted words transmit in order, separated by 1-clock idle gaps.
- Assert RESET for 1 clock halfway through the data bits of a frame with 3 words queued -> TXD=1 next clock, COUNT=0, BUSY=0, no further frames.
- Write with FULL=1 while the FSM is in IDLE popping -> the write is dropped, OVERRUN=1, COUNT decrements by 1.
